// File: rtl/flipflop_bank.sv
// -----------------------------------------------------------------------------
// flipflop_bank
//
// A register of WIDTH flip-flops that share one clock. All bits run in the
// same mode, which is selected at runtime. The mode can change on every
// cycle, and the block keeps no internal mode state.
//
//   mode 00 = D   : q_next = a
//   mode 01 = T   : q_next = q ^ a            (a is the toggle mask)
//   mode 10 = JK  : j = a, k = b; 00 hold, 01 clear, 10 set, 11 toggle
//   mode 11 = SR  : s = a, r = b; 00 hold, 01 clear, 10 set, 11 illegal
//                   An illegal bit holds its value. The other bits update
//                   normally.
//
// Next-state priority on each rising edge: clr, then en, then mode.
//
// Ports
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous, active-low reset
//   en       in   1      clock enable; 0 holds every bit
//   clr      in   1      synchronous load of RESET_VAL; overrides en and mode
//   mode     in   2      operating mode (see above)
//   a        in   WIDTH  D data / T mask / J / S, per bit
//   b        in   WIDTH  K / R, per bit; ignored in D and T modes
//   err_clr  in   1      synchronous clear of err (a new error wins)
//   q        out  WIDTH  registered state
//   qn       out  WIDTH  ~q, taken combinationally from q
//   changed  out  WIDTH  registered mask of bits that changed on the last edge
//   err      out  1      sticky flag: SR 1/1 was applied while enabled
// -----------------------------------------------------------------------------
module flipflop_bank #(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             err_clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn,
   output logic [WIDTH-1:0] changed,
   output logic             err
);

   typedef enum logic [1:0] {
      MODE_D  = 2'b00,
      MODE_T  = 2'b01,
      MODE_JK = 2'b10,
      MODE_SR = 2'b11
   } mode_e;

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_changed;
   logic             r_err;

   logic [WIDTH-1:0] w_mode_next;
   logic [WIDTH-1:0] w_q_next;
   logic             w_sr_illegal;
   logic             w_err_set;
   mode_e            w_mode;

   // JK characteristic equation applied across the whole vector:
   // q+ = j & ~q | ~k & q
   function automatic logic [WIDTH-1:0] jk_next(
      input logic [WIDTH-1:0] cur,
      input logic [WIDTH-1:0] j,
      input logic [WIDTH-1:0] k
   );
      jk_next = (j & ~cur) | (~k & cur);
   endfunction

   // SR next state. A bit with s = r = 1 keeps its current value. The
   // second term drops the current value only for a pure reset (r & ~s).
   function automatic logic [WIDTH-1:0] sr_next(
      input logic [WIDTH-1:0] cur,
      input logic [WIDTH-1:0] s,
      input logic [WIDTH-1:0] r
   );
      sr_next = (s & ~r) | (cur & ~(r & ~s));
   endfunction

   assign w_mode = mode_e'(mode);

   always_comb begin
      w_mode_next = r_q;
      case (w_mode)
         MODE_D:  w_mode_next = a;
         MODE_T:  w_mode_next = r_q ^ a;
         MODE_JK: w_mode_next = jk_next(r_q, a, b);
         MODE_SR: w_mode_next = sr_next(r_q, a, b);
         default: w_mode_next = r_q;
      endcase
   end

   // clr has priority over en, and en has priority over the mode function.
   assign w_q_next = clr ? RESET_VAL : (en ? w_mode_next : r_q);

   // The error is only raised for an SR cycle that would actually update q.
   assign w_sr_illegal = (w_mode == MODE_SR) && ((a & b) != '0);
   assign w_err_set    = en && !clr && w_sr_illegal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q       <= RESET_VAL;
         r_changed <= '0;
         r_err     <= 1'b0;
      end else begin
         r_q       <= w_q_next;
         // This is zero on a hold cycle. After clr it marks the bits that
         // differed from RESET_VAL.
         r_changed <= w_q_next ^ r_q;
         // Setting wins over err_clr. err_clr works even when en = 0.
         if (w_err_set)
            r_err <= 1'b1;
         else if (err_clr)
            r_err <= 1'b0;
      end
   end

   assign q       = r_q;
   assign qn      = ~r_q;
   assign changed = r_changed;
   assign err     = r_err;

endmodule

// File: tb/tb_flipflop_bank.sv
module tb_flipflop_bank;

   logic       clk;
   logic       rst_n;
   // WIDTH = 4 instance
   logic       en, clr, err_clr;
   logic [1:0] mode;
   logic [3:0] a, b;
   logic [3:0] q, qn, changed;
   logic       err;
   // WIDTH = 8, RESET_VAL = A5 instance
   logic       en8, clr8, err_clr8;
   logic [1:0] mode8;
   logic [7:0] a8, b8;
   logic [7:0] q8, qn8, changed8;
   logic       err8;

   int tests_run = 0;
   int tests_failed = 0;

   // reference model state for the 4-bit instance
   logic [3:0] m_q, m_changed;
   logic       m_err;

   flipflop_bank #(.WIDTH(4), .RESET_VAL(4'b0000)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .a(a), .b(b),
      .err_clr(err_clr), .q(q), .qn(qn), .changed(changed), .err(err)
   );

   flipflop_bank #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
      .clk(clk), .rst_n(rst_n), .en(en8), .clr(clr8), .mode(mode8), .a(a8), .b(b8),
      .err_clr(err_clr8), .q(q8), .qn(qn8), .changed(changed8), .err(err8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %0s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, "_q"},   {28'd0, q},       {28'd0, m_q});
      check({tag, "_qn"},  {28'd0, qn},      {28'd0, ~m_q});
      check({tag, "_chg"}, {28'd0, changed}, {28'd0, m_changed});
      check({tag, "_err"}, {31'd0, err},     {31'd0, m_err});
   endtask

   // Behavioural next state, worked out bit by bit from the mode truth tables.
   task automatic model_edge();
      logic [3:0] nq;
      logic       illegal;
      nq = m_q;
      illegal = 1'b0;
      if (clr) begin
         nq = 4'b0000;
      end else if (en) begin
         for (int i = 0; i < 4; i++) begin
            case (mode)
               2'd0: nq[i] = a[i];
               2'd1: nq[i] = m_q[i] ^ a[i];
               2'd2: case ({a[i], b[i]})
                        2'b01: nq[i] = 1'b0;
                        2'b10: nq[i] = 1'b1;
                        2'b11: nq[i] = ~m_q[i];
                        default: nq[i] = m_q[i];
                     endcase
               default: begin
                  case ({a[i], b[i]})
                     2'b01: nq[i] = 1'b0;
                     2'b10: nq[i] = 1'b1;
                     default: nq[i] = m_q[i];
                  endcase
                  if (a[i] && b[i]) illegal = 1'b1;
               end
            endcase
         end
      end
      m_changed = nq ^ m_q;
      m_q = nq;
      if (illegal) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
   endtask

   // Drive inputs away from the edge, step the model, clock, then sample at +1.
   task automatic step(input logic e, input logic c, input logic [1:0] md,
                       input logic [3:0] ia, input logic [3:0] ib, input logic ec);
      en = e; clr = c; mode = md; a = ia; b = ib; err_clr = ec;
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_q = 4'b0000; m_changed = 4'b0000; m_err = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      en = 0; clr = 0; err_clr = 0; mode = 0; a = 0; b = 0;
      en8 = 0; clr8 = 0; err_clr8 = 0; mode8 = 0; a8 = 0; b8 = 0;
      model_reset();
      #12;
      check("rst_q", {28'd0, q}, 32'h0);
      check("rst_qn", {28'd0, qn}, 32'hF);
      check("rst8_q", {24'd0, q8}, 32'hA5);
      check("rst8_qn", {24'd0, qn8}, 32'h5A);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // parameter check on the 8-bit instance: load FF, then clr
      en8 = 1; mode8 = 2'b00; a8 = 8'hFF;
      @(posedge clk); #1;
      check("p8_load_q", {24'd0, q8}, 32'hFF);
      en8 = 0; clr8 = 1;
      @(posedge clk); #1;
      check("p8_clr_q", {24'd0, q8}, 32'hA5);
      check("p8_clr_chg", {24'd0, changed8}, 32'h5A);
      clr8 = 0;
      // the 4-bit instance saw two edges with all inputs idle
      model_edge(); model_edge();

      // T mode
      step(1, 0, 2'b01, 4'b1111, 4'b0000, 0);
      check("t1_q", {28'd0, q}, 32'hF); check("t1_chg", {28'd0, changed}, 32'hF);
      step(1, 0, 2'b01, 4'b1111, 4'b0000, 0);
      check("t2_q", {28'd0, q}, 32'h0); check("t2_chg", {28'd0, changed}, 32'hF);
      step(1, 0, 2'b01, 4'b1111, 4'b0000, 0);
      check("t3_q", {28'd0, q}, 32'hF);
      step(1, 0, 2'b01, 4'b0101, 4'b0000, 0);
      check("t4_q", {28'd0, q}, 32'hA); check("t4_chg", {28'd0, changed}, 32'h5);
      check_model("tmode");

      // JK mode, starting from a cleared register
      step(1, 1, 2'b00, 4'b0000, 4'b0000, 0);
      step(1, 0, 2'b10, 4'b1100, 4'b1010, 0);
      check("jk_q", {28'd0, q}, 32'hC); check("jk_chg", {28'd0, changed}, 32'hC);
      check_model("jk");

      // SR illegal input and the sticky error
      step(1, 0, 2'b00, 4'b0110, 4'b0000, 0);
      step(1, 0, 2'b11, 4'b0011, 4'b0101, 0);
      check("sr_q", {28'd0, q}, 32'h2); check("sr_err", {31'd0, err}, 32'h1);
      step(1, 0, 2'b11, 4'b1000, 4'b0001, 0);
      check("sr_legal_err", {31'd0, err}, 32'h1);
      step(1, 0, 2'b11, 4'b0001, 4'b0001, 1);
      check("sr_setwins_err", {31'd0, err}, 32'h1);
      step(0, 0, 2'b00, 4'b0000, 4'b0000, 1);
      check("sr_errclr_err", {31'd0, err}, 32'h0);
      check_model("sr");

      // enable, clear, and err surviving clr
      step(1, 0, 2'b00, 4'b1011, 4'b0000, 0);
      step(1, 0, 2'b11, 4'b0100, 4'b0100, 0);
      check("en_err_set", {31'd0, err}, 32'h1);
      step(0, 0, 2'b00, 4'b1111, 4'b0000, 0);
      check("en0_q", {28'd0, q}, 32'hB); check("en0_chg", {28'd0, changed}, 32'h0);
      step(0, 0, 2'b00, 4'b1111, 4'b0000, 0);
      check("en0b_q", {28'd0, q}, 32'hB);
      step(1, 1, 2'b00, 4'b1111, 4'b0000, 0);
      check("clr_q", {28'd0, q}, 32'h0); check("clr_chg", {28'd0, changed}, 32'hB);
      check("clr_err", {31'd0, err}, 32'h1);
      check_model("enclr");

      // asynchronous reset mid-run with q = 1010 and err = 1
      step(1, 0, 2'b00, 4'b1010, 4'b0000, 0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("arst_q", {28'd0, q}, 32'h0); check("arst_qn", {28'd0, qn}, 32'hF);
      check("arst_chg", {28'd0, changed}, 32'h0); check("arst_err", {31'd0, err}, 32'h0);
      #1 rst_n = 1'b1;

      // randomized run against the model
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 5) != 0), ($urandom_range(0, 15) == 0),
              2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
              ($urandom_range(0, 7) == 0));
         check_model("rnd");
         if ($urandom_range(0, 49) == 0) begin
            #2 rst_n = 1'b0;
            #1 model_reset();
            check_model("rnd_rst");
            #1 rst_n = 1'b1;
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
